// File: rtl/rgb2bayer_pkg.sv
// Shared Bayer pattern codes, colour component codes and the pattern lookup
// used by rgb2bayer_mosaic.
package rgb2bayer_pkg;

  localparam logic [1:0] BAYER_RGGB = 2'b00;
  localparam logic [1:0] BAYER_GRBG = 2'b01;
  localparam logic [1:0] BAYER_GBRG = 2'b10;
  localparam logic [1:0] BAYER_BGGR = 2'b11;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  // parity is {line_odd, pixel_odd}
  function automatic logic [1:0] bayer_sel(input logic [1:0] pattern, input logic [1:0] parity);
    logic [1:0] comp;
    comp = COMP_G;
    case (pattern)
      BAYER_RGGB: comp = (parity == 2'b00) ? COMP_R : (parity == 2'b11) ? COMP_B : COMP_G;
      BAYER_GRBG: comp = (parity == 2'b01) ? COMP_R : (parity == 2'b10) ? COMP_B : COMP_G;
      BAYER_GBRG: comp = (parity == 2'b10) ? COMP_R : (parity == 2'b01) ? COMP_B : COMP_G;
      default:    comp = (parity == 2'b11) ? COMP_R : (parity == 2'b00) ? COMP_B : COMP_G;
    endcase
    return comp;
  endfunction

endpackage

// File: rtl/rgb2bayer_mosaic_delay.sv
// vip_delay_line: fixed-depth register shift line with async active-high reset.
// DEPTH of 0 degenerates to a wire.
module vip_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
        r_stage[0] <= i_data;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/rgb2bayer_mosaic.sv
// RGB stream to single-channel Bayer mosaic with per-frame pattern latch and
// geometry measurement. Define RGB2BAYER_TPG_EN to add the tpg_sel ramp source.
module rgb2bayer_mosaic
  import rgb2bayer_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned CNT_W           = 14,
  parameter int unsigned PIPE_STAGES     = 1,
  parameter logic [1:0]  DEFAULT_PATTERN = BAYER_RGGB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_bayer,
`ifdef RGB2BAYER_TPG_EN
  input  logic              tpg_sel,
`endif
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic              pre_frame_clken,
  input  logic [DATA_W-1:0] pre_img_red,
  input  logic [DATA_W-1:0] pre_img_green,
  input  logic [DATA_W-1:0] pre_img_blue,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_data_raw,
  output logic [1:0]        act_bayer,
  output logic [CNT_W-1:0]  line_width,
  output logic [CNT_W-1:0]  frame_lines,
  output logic              line_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_vsync_d, r_armed, r_active, r_href_d;
  logic [CNT_W-1:0]  r_hcnt, r_vcnt, r_line_width, r_frame_lines;
  logic [1:0]        r_act_bayer;
  logic              r_line_err;
  logic              r_s1_vsync, r_s1_href, r_s1_clken;
  logic [DATA_W-1:0] r_s1_data;

  logic              w_frame_start, w_in_frame, w_href, w_pix, w_line_end, w_frame_end;
  logic [CNT_W-1:0]  w_hcnt_cur, w_vcnt_cur, w_hcnt_inc, w_vcnt_inc, w_hcnt_next;
  logic [1:0]        w_pat;
  logic [DATA_W-1:0] w_sample, w_s1_in;
  logic [DATA_W+2:0] w_dly_out;

  // r_armed blocks a frame already running when reset released
  assign w_frame_start = pre_frame_vsync & ~r_vsync_d & r_armed;
  assign w_in_frame    = pre_frame_vsync & (r_active | w_frame_start);
  assign w_href        = w_in_frame & pre_frame_href;
  assign w_pix         = w_href & pre_frame_clken;
  // Gated href also drops when vsync falls, closing an open line at frame end
  assign w_line_end    = r_href_d & ~w_href;
  assign w_frame_end   = r_active & ~pre_frame_vsync;

  assign w_hcnt_cur = w_frame_start ? '0 : r_hcnt;
  assign w_vcnt_cur = w_frame_start ? '0 : r_vcnt;
  assign w_pat      = w_frame_start ? cfg_bayer : r_act_bayer;
  assign w_hcnt_inc = (w_hcnt_cur == CNT_MAX) ? w_hcnt_cur : w_hcnt_cur + CNT_W'(1);
  assign w_vcnt_inc = (r_vcnt == CNT_MAX) ? r_vcnt : r_vcnt + CNT_W'(1);

  always_comb begin
    w_hcnt_next = w_hcnt_cur;
    if (w_line_end) begin
      w_hcnt_next = '0;
    end else if (w_pix) begin
      w_hcnt_next = w_hcnt_inc;
    end
  end

  always_comb begin
    w_sample = pre_img_green;
    case (bayer_sel(w_pat, {w_vcnt_cur[0], w_hcnt_cur[0]}))
      COMP_R:  w_sample = pre_img_red;
      COMP_B:  w_sample = pre_img_blue;
      default: w_sample = pre_img_green;
    endcase
  end

`ifdef RGB2BAYER_TPG_EN
  logic             r_tpg;
  logic             w_tpg;
  logic [CNT_W:0]   w_ramp;

  assign w_tpg  = w_frame_start ? tpg_sel : r_tpg;
  assign w_ramp = {1'b0, w_hcnt_cur} + {1'b0, w_vcnt_cur};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tpg <= 1'b0;
    end else if (w_frame_start) begin
      r_tpg <= tpg_sel;
    end
  end

  assign w_s1_in = w_tpg ? DATA_W'(w_ramp) : w_sample;
`else
  assign w_s1_in = w_sample;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d     <= 1'b0;
      r_armed       <= 1'b0;
      r_active      <= 1'b0;
      r_href_d      <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_line_width  <= '0;
      r_frame_lines <= '0;
      r_act_bayer   <= DEFAULT_PATTERN;
      r_line_err    <= 1'b0;
    end else begin
      r_vsync_d <= pre_frame_vsync;
      r_armed   <= r_armed | ~pre_frame_vsync;
      r_active  <= w_in_frame;
      r_href_d  <= w_href;
      r_hcnt    <= w_hcnt_next;
      if (w_frame_start) begin
        r_act_bayer <= cfg_bayer;
        r_vcnt      <= '0;
        r_line_err  <= 1'b0;
      end
      if (w_line_end) begin
        r_line_width <= r_hcnt;
        r_vcnt       <= w_vcnt_inc;
        if (r_vcnt != '0 && r_hcnt != r_line_width) r_line_err <= 1'b1;
      end
      if (w_frame_end) begin
        r_frame_lines <= w_line_end ? w_vcnt_inc : r_vcnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vsync <= 1'b0;
      r_s1_href  <= 1'b0;
      r_s1_clken <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_vsync <= w_in_frame;
      r_s1_href  <= w_href;
      r_s1_clken <= w_pix;
      if (w_pix) begin
        r_s1_data <= w_s1_in;
      end else if (!w_href) begin
        r_s1_data <= '0;
      end
    end
  end

  vip_delay_line #(
    .WIDTH (DATA_W + 3),
    .DEPTH (PIPE_STAGES - 1)
  ) u_delay (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data ({r_s1_vsync, r_s1_href, r_s1_clken, r_s1_data}),
    .o_data (w_dly_out)
  );

  assign post_frame_vsync = w_dly_out[DATA_W+2];
  assign post_frame_href  = w_dly_out[DATA_W+1];
  assign post_frame_clken = w_dly_out[DATA_W];
  assign post_data_raw    = post_frame_href ? w_dly_out[DATA_W-1:0] : '0;

  assign act_bayer   = r_act_bayer;
  assign line_width  = r_line_width;
  assign frame_lines = r_frame_lines;
  assign line_err    = r_line_err;

endmodule

// File: tb/tb_rgb2bayer_mosaic.sv
// Randomised scoreboard bench for rgb2bayer_mosaic (12-bit data, 3-cycle latency).
module tb_rgb2bayer_mosaic;

  localparam int unsigned DW   = 12;
  localparam int unsigned CW   = 14;
  localparam int unsigned PIPE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_bayer = 2'b00;
  logic          pre_frame_vsync = 1'b0, pre_frame_href = 1'b0, pre_frame_clken = 1'b0;
  logic [DW-1:0] pre_img_red = '0, pre_img_green = '0, pre_img_blue = '0;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [DW-1:0] post_data_raw;
  logic [1:0]    act_bayer;
  logic [CW-1:0] line_width, frame_lines;
  logic          line_err;

  rgb2bayer_mosaic #(
    .DATA_W          (DW),
    .CNT_W           (CW),
    .PIPE_STAGES     (PIPE),
    .DEFAULT_PATTERN (2'b00)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_bayer        (cfg_bayer),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_href   (pre_frame_href),
    .pre_frame_clken  (pre_frame_clken),
    .pre_img_red      (pre_img_red),
    .pre_img_green    (pre_img_green),
    .pre_img_blue     (pre_img_blue),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_data_raw    (post_data_raw),
    .act_bayer        (act_bayer),
    .line_width       (line_width),
    .frame_lines      (frame_lines),
    .line_err         (line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  string pat_name[4] = '{"RGGB", "GRBG", "GBRG", "BGGR"};
  int m_pat = 0, m_x = 0, m_y = 0;
  bit m_live = 1'b0;
  int plan_w[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel
  logic [DW-1:0] last_val = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!post_frame_href) begin
        check("raw_zero_outside_href", post_data_raw, 0);
        last_val = '0;
      end else if (post_frame_clken) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pixel_data", post_data_raw, e.data);
          check("pixel_latency", cyc - e.cyc, PIPE);
          check("pixel_vsync", post_frame_vsync, 1);
          last_val = e.data;
        end
      end else begin
        check("hold_between_pixels", post_data_raw, last_val);
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic c);
    pre_frame_vsync = v;
    pre_frame_href  = h;
    pre_frame_clken = c;
    pre_img_red     = DW'($urandom);
    pre_img_green   = DW'($urandom);
    pre_img_blue    = DW'($urandom);
    if (m_live && v && h && c) begin
      byte  ch;
      exp_t e;
      ch = pat_name[m_pat][(m_y % 2) * 2 + (m_x % 2)];
      e.data = (ch == "R") ? pre_img_red : (ch == "B") ? pre_img_blue : pre_img_green;
      e.cyc  = cyc;
      sb.push_back(e);
      m_x++;
    end
    @(posedge clk);
    #1;
  endtask

  // mode: 0 clken always, 1 alternating, 2 random
  task automatic run_frame(input int pat, input int nlines, input int mode, input int cfg_mid,
                           input bit vs_cut);
    bit exp_err;
    exp_err   = 1'b0;
    cfg_bayer = 2'(pat);
    m_pat     = pat;
    m_y       = 0;
    m_live    = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    check("act_bayer_latch", act_bayer, pat);
    check("line_err_clear", line_err, 0);
    for (int l = 0; l < nlines; l++) begin
      int w;
      int k;
      bit last_cut;
      w = plan_w[l];
      k = 0;
      m_x = 0;
      if (w == 0) drive(1'b1, 1'b1, 1'b0);
      while (m_x < w) begin
        logic c;
        case (mode)
          0:       c = 1'b1;
          1:       c = (k % 2 == 0);
          default: c = 1'($urandom % 2);
        endcase
        drive(1'b1, 1'b1, c);
        k++;
      end
      last_cut = vs_cut && (l == nlines - 1);
      drive(!last_cut, 1'b0, 1'b0);
      if (l > 0 && w != plan_w[l-1]) exp_err = 1'b1;
      check("line_width", line_width, w);
      check("line_err", line_err, exp_err);
      m_y++;
      if (l == 0 && cfg_mid >= 0) cfg_bayer = 2'(cfg_mid);
      check("act_bayer_hold", act_bayer, pat);
    end
    if (!vs_cut) drive(1'b0, 1'b0, 1'b0);
    check("frame_lines", frame_lines, nlines);
    check("line_err_sticky", line_err, exp_err);
    check("act_bayer_end", act_bayer, pat);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("rst_act_bayer", act_bayer, 0);
    check("rst_line_width", line_width, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_line_err", line_err, 0);
    check("rst_post_vsync", post_frame_vsync, 0);
    check("rst_post_data", post_data_raw, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // RGGB 4x2, clken every cycle
    plan_w[0] = 4; plan_w[1] = 4;
    run_frame(0, 2, 0, -1, 1'b0);
    // Mid-frame pattern change, then the new pattern takes effect
    plan_w[2] = 4;
    run_frame(0, 3, 0, 3, 1'b0);
    run_frame(int'(cfg_bayer), 2, 0, -1, 1'b0);
    // Alternating clken
    run_frame(1, 2, 1, -1, 1'b0);
    // Widths 6,6,5
    plan_w[0] = 6; plan_w[1] = 6; plan_w[2] = 5;
    run_frame(2, 3, 2, -1, 1'b0);
    // Zero-width line, vsync drops with href still high
    plan_w[0] = 3; plan_w[1] = 0; plan_w[2] = 3;
    run_frame(1, 3, 2, -1, 1'b1);

    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = int'($urandom_range(1, 5));
      for (int l = 0; l < nl; l++)
        plan_w[l] = (l > 0 && $urandom_range(0, 1) == 1) ? plan_w[l-1]
                                                         : int'($urandom_range(1, 9));
      run_frame(int'($urandom_range(0, 3)), nl, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)) - 1, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a line
    plan_w[0] = 5; plan_w[1] = 5;
    cfg_bayer = 2'b10;
    m_pat = 2; m_y = 0; m_x = 0; m_live = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    sb.delete();
    m_live = 1'b0;
    check("rstmid_act_bayer", act_bayer, 0);
    check("rstmid_line_width", line_width, 0);
    check("rstmid_frame_lines", frame_lines, 0);
    check("rstmid_line_err", line_err, 0);
    check("rstmid_post_href", post_frame_href, 0);
    check("rstmid_post_clken", post_frame_clken, 0);
    check("rstmid_post_data", post_data_raw, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Rest of the interrupted frame must be ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1);
    check("ignored_post_vsync", post_frame_vsync, 0);
    drive(1'b1, 1'b0, 1'b0);
    check("ignored_line_width", line_width, 0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("ignored_frame_lines", frame_lines, 0);
    check("ignored_act_bayer", act_bayer, 0);
    run_frame(2, 2, 2, -1, 1'b0);

    for (int i = 0; i < int'(PIPE) + 2; i++) drive(1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
